sd_read_arbiter: RTL and testbench
==================================

# sd_read_arbiter

Shares the single SD-card sector-read port between several audio requesters, e.g. the background-music streamer and the sound-effect player, each driving its own SD-to-FIFO loader. It arbitrates round-robin at sector granularity, forwards the owner's address to the SD controller, and steers the returned byte stream back to the owner only. It also detects stalled sectors. It sits between the SD controller and all audio clients.

## Interface
- NUM_CLIENTS, 2: number of requesters (2..4).
- SECTOR_BYTES, 512: bytes delivered per SD read command.
- TIMEOUT_CYCLES, 1000000: maximum gap between bytes (or between command and first byte) before the sector is abandoned.
- clk_in  in  1  system clock.
- reset_in  in  1  asynchronous, active-high reset.
- client_req  in  NUM_CLIENTS  level request per client; held until that client's accept pulse.
- client_addr  in  32*NUM_CLIENTS  sector address per client; client i occupies bits [32i+31:32i].
- client_read_accepted  out  NUM_CLIENTS  one-cycle pulse to the granted client when its command is issued.
- client_byte_available  out  NUM_CLIENTS  one-cycle pulse to the owner per forwarded byte.
- client_dout  out  8  forwarded byte, shared by all clients; valid only with the owner's byte_available.
- sd_ready  in  1  SD controller idle and able to take a command.
- sd_rd  out  1  read command strobe.
- sd_addr  out  32  sector address to the controller.
- sd_byte_available  in  1  controller byte strobe.
- sd_dout  in  8  controller byte.
- busy  out  1  high in every state except IDLE.
- owner  out  2  index of the current or last granted client.
- timeout_err  out  1  one-cycle pulse when a sector is abandoned.

## Operation
- The state machine has four states: IDLE, ISSUE, TRANSFER, DRAIN.
- **IDLE**
  - Arbitration runs only here, and only when sd_ready=1 and client_req≠0.
  - Grant goes to the first requesting index after `owner`, searching upward and wrapping modulo NUM_CLIENTS.
  - In the same edge: register the new owner, latch sd_addr from that client's slice, pulse client_read_accepted[owner], and go to ISSUE.
- **ISSUE**
  - sd_rd=1 for exactly this one cycle.
  - Clear the byte counter and timeout counter, then go to TRANSFER.
- **TRANSFER**
  - On each sd_byte_available: increment the 10-bit byte counter, clear the timeout counter, register client_dout=sd_dout, and pulse client_byte_available[owner].
  - When the counter reaches SECTOR_BYTES (on the edge that forwards the 512th byte), go to DRAIN.
  - Otherwise the timeout counter increments each cycle. At TIMEOUT_CYCLES-1, pulse timeout_err and go to DRAIN.
- **DRAIN**
  - Wait for sd_ready=1, then go to IDLE. The arbitration pass happens on the next cycle.
  - Bytes arriving in DRAIN are discarded and not forwarded.
- Bytes arriving in IDLE or ISSUE are discarded.
- A non-owner request raised during ISSUE, TRANSFER or DRAIN stays pending and is served in later IDLE passes.
- A client that drops client_req before being granted is skipped and receives no accept pulse.
- The owner's client_req and client_addr are ignored after the grant, so an early deassert does not truncate the sector.

## Timing
- **Reset values:** state=IDLE, sd_rd=0, sd_addr=0, client_read_accepted=0, client_byte_available=0, client_dout=0, busy=0, owner=NUM_CLIENTS-1, timeout_err=0. With owner=NUM_CLIENTS-1, the first grant goes to client 0.
- **Request to command:** a request seen in IDLE with sd_ready=1 at edge t produces the accept pulse and ISSUE in the cycle after t, with sd_rd=1 in that same cycle.
- **Byte forwarding latency:** exactly 1 cycle from sd_byte_available to client_byte_available.
- **Minimum cycles between two grants:** 3 + SECTOR_BYTES byte strobes + the DRAIN wait.
- **Reset mid-transfer:** all outputs drop immediately (asynchronous). The controller's leftover bytes are then discarded because the block is in IDLE. No new command is issued until sd_ready=1.
- **Width rule:** the byte counter is 10 bits and never wraps, because it exits at 512. The timeout counter is $clog2(TIMEOUT_CYCLES) bits wide.

## Test plan
- **Single client:** client 0 requests addr 0x0040_2000 with sd_ready=1, then 512 bytes 0x00..0xFF repeating are fed.
  - Required: one accept pulse, sd_rd for 1 cycle with sd_addr=0x0040_2000.
  - Required: 512 byte_available[0] pulses, each 1 cycle late, with matching data; byte_available[1] never pulses.
- **Round-robin fairness:** both clients request continuously.
  - Required: grants alternate 0,1,0,1 across 4 sectors.
  - Required: each accept occurs only after DRAIN sees sd_ready=1.
- **Late request:** client 1 requests midway through client 0's sector.
  - Required: no sd_rd until client 0's 512th byte and sd_ready=1, then client 1 is granted with its address.
- **Timeout:** TIMEOUT_CYCLES=100, only 10 bytes are delivered.
  - Required: timeout_err pulses 100 cycles after the 10th byte; the block goes to DRAIN, then IDLE once sd_ready=1.
  - Required: a late byte arriving in DRAIN is not forwarded.
- **Reset mid-transfer:** reset_in asserts after 200 bytes while the controller continues to stream.
  - Required: all outputs are 0 immediately; no forwarded bytes; the next request is granted only after sd_ready=1.
- **Early request drop:** client 1 asserts client_req for one cycle while sd_ready=0.
  - Required: no accept pulse, no sd_rd.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// Round-robin owner of the single SD sector-read port: grants one client per sector,
// forwards its command and steers the returned byte stream back to that client only.
module sd_read_arbiter #(
  parameter int NUM_CLIENTS    = 2,
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [NUM_CLIENTS-1:0]   client_req,
  input  logic [32*NUM_CLIENTS-1:0] client_addr,
  output logic [NUM_CLIENTS-1:0]   client_read_accepted,
  output logic [NUM_CLIENTS-1:0]   client_byte_available,
  output logic [7:0]               client_dout,
  input  logic                     sd_ready,
  output logic                     sd_rd,
  output logic [31:0]              sd_addr,
  input  logic                     sd_byte_available,
  input  logic [7:0]               sd_dout,
  output logic                     busy,
  output logic [1:0]               owner,
  output logic                     timeout_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, TRANSFER, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [9:0]             byte_cnt;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [1:0]             grant_idx;
  logic                   grant_vld;
  logic [31:0]            grant_addr;
  logic [3:0]             req_ext;
  logic [1:0]             cand_idx;
  logic                   last_byte;
  logic                   tmo_hit;

  function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [1:0] idx);
    logic [NUM_CLIENTS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) v[i] = (idx == 2'(i));
    return v;
  endfunction

  assign busy      = (state_q != IDLE);
  assign last_byte = sd_byte_available && (byte_cnt == 10'(SECTOR_BYTES - 1));
  assign tmo_hit   = !sd_byte_available && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Search starts just above the previous owner so every requester gets a turn.
  always_comb begin
    req_ext   = 4'(client_req);
    grant_idx = owner;
    grant_vld = 1'b0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_CLIENTS; k++) begin
      cand_idx = 2'((int'(owner) + k) % NUM_CLIENTS);
      if (!grant_vld && req_ext[cand_idx]) begin
        grant_idx = cand_idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      if (grant_idx == 2'(i)) grant_addr = client_addr[32*i +: 32];
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (sd_ready && grant_vld) state_d = ISSUE;
      ISSUE:    state_d = TRANSFER;
      TRANSFER: if (last_byte || tmo_hit) state_d = DRAIN;
      DRAIN:    if (sd_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Command issue and byte forwarding stage; strobes default low each cycle.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      owner                 <= 2'(NUM_CLIENTS - 1);
      sd_addr               <= '0;
      sd_rd                 <= 1'b0;
      client_read_accepted  <= '0;
      client_byte_available <= '0;
      client_dout           <= '0;
      timeout_err           <= 1'b0;
      byte_cnt              <= '0;
      tmo_cnt               <= '0;
    end else begin
      sd_rd                 <= 1'b0;
      client_read_accepted  <= '0;
      client_byte_available <= '0;
      timeout_err           <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sd_ready && grant_vld) begin
            owner                <= grant_idx;
            sd_addr              <= grant_addr;
            sd_rd                <= 1'b1;
            client_read_accepted <= onehot(grant_idx);
          end
        end
        ISSUE: begin
          byte_cnt <= '0;
          tmo_cnt  <= '0;
        end
        TRANSFER: begin
          if (sd_byte_available) begin
            byte_cnt              <= byte_cnt + 10'd1;
            tmo_cnt               <= '0;
            client_dout           <= sd_dout;
            client_byte_available <= onehot(owner);
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter: a sector-level reference model checked every
// cycle, plus literal expectations for grants, counts and timeout spacing.
module tb_sd_read_arbiter;

  localparam int NC = 2;
  localparam int SB = 512;
  localparam int TO = 100;

  logic              clk_in = 1'b0;
  logic              reset_in = 1'b1;
  logic [NC-1:0]     client_req = '0;
  logic [32*NC-1:0]  client_addr;
  logic [NC-1:0]     client_read_accepted;
  logic [NC-1:0]     client_byte_available;
  logic [7:0]        client_dout;
  logic              sd_ready = 1'b0;
  logic              sd_rd;
  logic [31:0]       sd_addr;
  logic              sd_byte_available = 1'b0;
  logic [7:0]        sd_dout = '0;
  logic              busy;
  logic [1:0]        owner;
  logic              timeout_err;

  logic [31:0]       addr_tb [NC];
  bit                drop_on_acc = 1'b0;

  assign client_addr = {addr_tb[1], addr_tb[0]};

  sd_read_arbiter #(.NUM_CLIENTS(NC), .SECTOR_BYTES(SB), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .client_req(client_req), .client_addr(client_addr),
    .client_read_accepted(client_read_accepted),
    .client_byte_available(client_byte_available),
    .client_dout(client_dout),
    .sd_ready(sd_ready), .sd_rd(sd_rd), .sd_addr(sd_addr),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .busy(busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Sector-level reference: who owns the port, how far into the sector, how long silent.
  int          m_owner = NC - 1;
  bit          m_busy = 0, m_cmd = 0, m_data = 0;
  int          m_bytes = 0, m_quiet = 0;
  logic [31:0] e_addr = '0;
  logic [7:0]  e_dout = '0;
  logic [NC-1:0] e_acc = '0, e_bav = '0;
  logic        e_rd = 0, e_terr = 0;

  always @(posedge clk_in or posedge reset_in) begin
    int pick;
    bit [31:0] req32;
    if (reset_in) begin
      m_owner = NC - 1; m_busy = 0; m_cmd = 0; m_data = 0; m_bytes = 0; m_quiet = 0;
      e_addr = '0; e_dout = '0; e_acc = '0; e_bav = '0; e_rd = 0; e_terr = 0;
    end else begin
      e_acc = '0; e_bav = '0; e_rd = 0; e_terr = 0;
      req32 = 32'(client_req);
      if (!m_busy) begin
        if (sd_ready && client_req != '0) begin
          pick = -1;
          for (int k = 1; k <= NC; k++)
            if (pick < 0 && req32[((m_owner + k) % NC) & 31]) pick = (m_owner + k) % NC;
          m_owner = pick;
          e_addr = addr_tb[pick[0]];
          e_acc[pick[0]] = 1'b1;
          e_rd = 1'b1;
          m_busy = 1; m_cmd = 1;
        end
      end else if (m_cmd) begin
        m_cmd = 0; m_data = 1; m_bytes = 0; m_quiet = 0;
      end else if (m_data) begin
        if (sd_byte_available) begin
          m_bytes++; m_quiet = 0;
          e_dout = sd_dout;
          e_bav[m_owner & 1] = 1'b1;
          if (m_bytes == SB) m_data = 0;
        end else begin
          m_quiet++;
          if (m_quiet == TO) begin e_terr = 1'b1; m_data = 0; end
        end
      end else if (sd_ready) begin
        m_busy = 0;
      end
    end
  end

  int cyc = 0, rd_cnt = 0, acc_cnt = 0, bav_cnt0 = 0, bav_cnt1 = 0;
  int last_bav_cyc = 0, terr_cyc = 0;
  int grants[$];

  always @(negedge clk_in) begin
    cyc++;
    check("sd_rd", 32'(sd_rd), 32'(e_rd));
    check("sd_addr", sd_addr, e_addr);
    check("accept", 32'(client_read_accepted), 32'(e_acc));
    check("byte_avail", 32'(client_byte_available), 32'(e_bav));
    check("client_dout", 32'(client_dout), 32'(e_dout));
    check("busy", 32'(busy), 32'(m_busy));
    check("owner", 32'(owner), 32'(m_owner));
    check("timeout_err", 32'(timeout_err), 32'(e_terr));
    if (sd_rd) rd_cnt++;
    if (client_read_accepted != '0) begin acc_cnt++; grants.push_back(int'(owner)); end
    if (client_byte_available[0]) begin bav_cnt0++; last_bav_cyc = cyc; end
    if (client_byte_available[1]) bav_cnt1++;
    if (timeout_err) terr_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
    if (drop_on_acc) client_req = client_req & ~client_read_accepted;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (sd_rd) ok = 1;
    end
  endtask

  task automatic feed(int n, int start, int gap);
    for (int j = 0; j < n; j++) begin
      sd_byte_available = 1'b1;
      sd_dout = 8'(start + j);
      tick();
      sd_byte_available = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int b0, b1, rbase, abase;
    int exp_rr[4] = '{0, 1, 0, 1};
    addr_tb[0] = '0; addr_tb[1] = '0;

    repeat (3) tick();
    reset_in = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_addr", sd_addr, 32'd0);
    check("rst_rd", 32'(sd_rd), 32'd0);

    // single client, full sector
    drop_on_acc = 1; addr_tb[0] = 32'h0040_2000; client_req = 2'b01; sd_ready = 1;
    wait_rd(ok);
    check("single_grant", 32'(ok), 32'd1);
    check("single_addr", sd_addr, 32'h0040_2000);
    check("single_acc", 32'(client_read_accepted), 32'd1);
    b0 = bav_cnt0; b1 = bav_cnt1; rbase = rd_cnt;
    sd_ready = 0; tick();
    feed(SB, 0, 0);
    repeat (3) tick();
    check("single_drain_busy", 32'(busy), 32'd1);
    sd_ready = 1; repeat (3) tick();
    check("single_cnt0", 32'(bav_cnt0 - b0), 32'd512);
    check("single_cnt1", 32'(bav_cnt1 - b1), 32'd0);
    check("single_rd_once", 32'(rd_cnt - rbase), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // late request from client 1 midway through client 0's sector
    addr_tb[0] = 32'h0050_0000; addr_tb[1] = 32'h0000_1234; client_req = 2'b01;
    wait_rd(ok);
    check("late_grant0", 32'(ok), 32'd1);
    sd_ready = 0; tick();
    feed(256, 0, 0);
    client_req[1] = 1'b1; rbase = rd_cnt;
    feed(256, 256, 0);
    repeat (4) tick();
    check("late_no_rd", 32'(rd_cnt - rbase), 32'd0);
    check("late_drain_busy", 32'(busy), 32'd1);
    sd_ready = 1;
    wait_rd(ok);
    check("late_grant1", 32'(ok), 32'd1);
    check("late_addr", sd_addr, 32'h0000_1234);
    check("late_owner", 32'(owner), 32'd1);
    sd_ready = 0; tick();
    feed(SB, 7, 0);
    repeat (2) tick();
    sd_ready = 1; repeat (3) tick();

    // round robin with both clients requesting continuously
    drop_on_acc = 0; grants.delete();
    addr_tb[0] = 32'h0000_0A00; addr_tb[1] = 32'h0000_0B00; client_req = 2'b11;
    for (int s = 0; s < 4; s++) begin
      wait_rd(ok);
      check("rr_grant", 32'(ok), 32'd1);
      if (s == 3) client_req = 2'b00;
      sd_ready = 0; tick();
      feed(SB, s * 16, (s == 1) ? 1 : 0);
      repeat (3) tick();
      check("rr_hold_rd", 32'(sd_rd), 32'd0);
      check("rr_hold_busy", 32'(busy), 32'd1);
      sd_ready = 1;
    end
    repeat (4) tick();
    check("rr_count", 32'(grants.size()), 32'd4);
    for (int s = 0; s < 4; s++)
      check("rr_order", 32'((s < grants.size()) ? grants[s] : -1), 32'(exp_rr[s]));

    // request pulsed while the controller is not ready
    abase = acc_cnt; rbase = rd_cnt;
    sd_ready = 0; client_req = 2'b10; tick();
    client_req = 2'b00; repeat (5) tick();
    sd_ready = 1; repeat (5) tick();
    check("drop_acc", 32'(acc_cnt - abase), 32'd0);
    check("drop_rd", 32'(rd_cnt - rbase), 32'd0);

    // stalled sector: only 10 bytes, then a stray byte during drain
    drop_on_acc = 1; addr_tb[0] = 32'h0000_7700; client_req = 2'b01;
    wait_rd(ok);
    check("to_grant", 32'(ok), 32'd1);
    b0 = bav_cnt0;
    sd_ready = 0; tick();
    feed(10, 8'hA0, 0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (timeout_err) ok = 1;
    end
    check("to_seen", 32'(ok), 32'd1);
    tick();
    check("to_delay", 32'(terr_cyc - last_bav_cyc), 32'd100);
    sd_byte_available = 1; sd_dout = 8'h55; tick();
    sd_byte_available = 0; repeat (2) tick();
    check("to_cnt", 32'(bav_cnt0 - b0), 32'd10);
    check("to_dout", 32'(client_dout), 32'hA9);
    check("to_drain_busy", 32'(busy), 32'd1);
    sd_ready = 1; repeat (2) tick();
    check("to_idle", 32'(busy), 32'd0);

    // reset in the middle of a streaming sector
    addr_tb[0] = 32'h0000_9900; client_req = 2'b01;
    wait_rd(ok);
    check("rm_grant", 32'(ok), 32'd1);
    sd_ready = 0; tick();
    feed(200, 0, 0);
    sd_byte_available = 1; sd_dout = 8'hC8; reset_in = 1;
    b0 = bav_cnt0; rbase = rd_cnt;
    #1;
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_bav", 32'(client_byte_available), 32'd0);
    check("rm_dout", 32'(client_dout), 32'd0);
    check("rm_addr", sd_addr, 32'd0);
    check("rm_rd", 32'(sd_rd), 32'd0);
    check("rm_owner", 32'(owner), 32'd1);
    for (int j = 0; j < 3; j++) begin tick(); sd_dout = sd_dout + 8'd1; end
    reset_in = 0; client_req = 2'b01;
    for (int j = 0; j < 20; j++) begin tick(); sd_dout = sd_dout + 8'd1; end
    check("rm_no_fwd", 32'(bav_cnt0 - b0), 32'd0);
    check("rm_no_rd", 32'(rd_cnt - rbase), 32'd0);
    check("rm_idle", 32'(busy), 32'd0);
    sd_byte_available = 0; sd_ready = 1;
    wait_rd(ok);
    check("rm_regrant", 32'(ok), 32'd1);
    check("rm_regrant_addr", sd_addr, 32'h0000_9900);
    check("rm_regrant_owner", 32'(owner), 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
